dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_W, 32, data width; DEPTH_BYTES, 512, byte capacity, addressed by 9 bits; WAIT_CYCLES, 2, wait states per access, legal range 0..15.
REQ-002 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1, asynchronous active-high reset.
REQ-004 Port req_valid, input, 1, core presents a load/store request.
REQ-005 Port req_ready, output, 1, responder can accept a request.
REQ-006 Port req_we, input, 1, 1 = store, 0 = load.
REQ-007 Port req_addr, input, 9, byte address.
REQ-008 Port req_funct3, input, 3, RISC-V access size and sign code.
REQ-009 Port req_wdata, input, DATA_W, store data, right-aligned.
REQ-010 Port rsp_valid, output, 1, one-cycle response strobe.
REQ-011 Port rsp_rdata, output, DATA_W, extended load data.
REQ-012 Port rsp_err, output, 1, access was misaligned or had an illegal funct3.

Function
REQ-013 Storage SHALL be DEPTH_BYTES/4 little-endian words.
- Word index = addr[8:2].
- Byte k of a word = bits [8k+7:8k].
REQ-014 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE.
REQ-016 A request is accepted on the edge where req_valid & req_ready = 1.
- On acceptance, we, addr, funct3 and wdata SHALL be captured.
- Port inputs SHALL be ignored until the FSM returns to IDLE.
REQ-017 Transitions SHALL be:
- IDLE->WAIT on acceptance when WAIT_CYCLES > 0.
- IDLE->RESP on acceptance when WAIT_CYCLES = 0.
- WAIT->RESP after WAIT_CYCLES cycles in WAIT; a 4-bit counter loaded on acceptance and decremented each cycle.
- RESP->IDLE unconditionally.
REQ-018 The memory read or write SHALL commit on the edge entering RESP.
- rsp_valid = 1 for exactly one cycle, RESP.
- With acceptance in cycle 0, rsp_valid SHALL be high in cycle WAIT_CYCLES+1 and req_ready high again in cycle WAIT_CYCLES+2.
REQ-019 Load funct3 decoding SHALL be:
- 000 LB: sign-extend the byte at addr[1:0].
- 001 LH: sign-extend the halfword at addr[1].
- 010 LW: the full word.
- 100 LBU: zero-extend the byte.
- 101 LHU: zero-extend the halfword.
REQ-020 Store funct3 decoding SHALL be:
- 000 SB: write wdata[7:0] to the addressed byte lane only.
- 001 SH: write wdata[15:0] to the addressed half.
- 010 SW: write the full word.
- Unaddressed lanes SHALL be unchanged.
REQ-021 The following SHALL be an error:
- Halfword access with addr[0] = 1.
- Word access with addr[1:0] != 0.
- Any other funct3, for either a load or a store.
REQ-022 An error access SHALL:
- keep the same latency as a legal access;
- assert rsp_err = 1 and rsp_rdata = 0 in RESP;
- not modify storage.
REQ-023 In every cycle other than RESP: rsp_rdata = 0, rsp_err = 0. For a legal store in RESP: rsp_rdata = 0.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 When reset asserts, the following SHALL occur immediately, regardless of clk:
- state = IDLE; counter = 0;
- req_ready = 1;
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-026 Storage contents SHALL NOT be cleared by reset.
REQ-027 A request in WAIT when reset asserts SHALL be discarded.
- Its write SHALL never commit.
- No rsp_valid pulse SHALL follow for it.

Verification (WAIT_CYCLES = 2)
REQ-028 Word round trip:
- SW 0x010 data 0xDEADBEEF, then LW 0x010 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- For each access, rsp_valid pulses exactly 3 cycles after acceptance, for 1 cycle.
REQ-029 Byte store and loads:
- SW 0x010 = 0x11223344, then SB 0x011 data 0x000000AA.
- LW 0x010 -> 0x1122AA44; LB 0x011 -> 0xFFFFFFAA; LBU 0x011 -> 0x000000AA.
REQ-030 Halfword store and loads:
- SH 0x012 data 0x00008001.
- LH 0x012 -> 0xFFFF8001; LHU 0x012 -> 0x00008001; LW 0x010 -> 0x8001AA44.
REQ-031 Errors:
- LW 0x013 -> rsp_err = 1, rsp_rdata = 0.
- SH 0x021 data 0xFFFF after SW 0x020 = 0x0 -> rsp_err = 1; LW 0x020 -> 0x00000000.
- Load funct3 = 011 -> rsp_err = 1.
REQ-032 Reset mid-operation:
- SW 0x040 = 0x0, then SW 0x040 data 0x12345678 with reset pulsed in WAIT.
- rsp_valid stays 0 for that request; req_ready = 1 during reset; LW 0x040 -> 0x00000000.
REQ-033 Back-to-back and top of memory:
- req_valid held high with SW 0x1FC = 0xCAFEF00D then LW 0x1FC.
- Second acceptance occurs 4 cycles after the first; req_ready = 0 in between; load returns 0xCAFEF00D.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-addressable data memory responder with fixed wait states
//
// Purpose: serves RISC-V style loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW)
// against an internal little-endian word array. Every access, legal or not,
// takes WAIT_CYCLES+1 cycles from acceptance to its single-cycle response.
//
// Ports:
//   clk         - single clock, rising edge
//   reset       - asynchronous active-high reset (storage is not cleared)
//   req_valid   - request present
//   req_ready   - responder idle and able to accept (registered)
//   req_we      - 1 = store, 0 = load
//   req_addr    - byte address
//   req_funct3  - access size / sign code
//   req_wdata   - right-aligned store data
//   rsp_valid   - one-cycle response strobe (registered)
//   rsp_rdata   - extended load data, zero otherwise (registered)
//   rsp_err     - misaligned access or illegal funct3 (registered)

module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [8:0]        req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int LANES = DATA_W / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [DATA_W-1:0] mem [WORDS];

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [8:0]        addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept;
  logic              enter_resp;
  logic              acc_we;
  logic [8:0]        acc_addr;
  logic [2:0]        acc_f3;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_err;
  logic [DATA_W-1:0] rd_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_data;
  logic [LANES-1:0]  st_be;
  logic              mem_we;

  // The access being committed: with zero wait states the commit happens on
  // the acceptance edge itself, so the live port values are used; otherwise
  // the values captured at acceptance are used.
  always_comb begin
    accept = req_valid & req_ready_q & (state_q == S_IDLE) & ~reset;
    if (state_q == S_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_f3    = req_funct3;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_f3    = funct3_q;
      acc_wdata = wdata_q;
    end
  end

  // Legality: stores only have byte/half/word codes, loads add the unsigned variants.
  always_comb begin
    acc_err = 1'b0;
    case (acc_f3)
      3'b000:  acc_err = 1'b0;
      3'b001:  acc_err = acc_addr[0];
      3'b010:  acc_err = (acc_addr[1:0] != 2'b00);
      3'b100:  acc_err = acc_we;
      3'b101:  acc_err = acc_we | acc_addr[0];
      default: acc_err = 1'b1;
    endcase
  end

  always_comb begin
    rd_word = mem[acc_addr[8:2]];
    ld_byte = rd_word[{acc_addr[1:0], 3'b000} +: 8];
    ld_half = rd_word[{acc_addr[1], 4'b0000} +: 16];
    ld_data = '0;
    case (acc_f3)
      3'b000:  ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = DATA_W'(ld_byte);
      3'b101:  ld_data = DATA_W'(ld_half);
      default: ld_data = '0;
    endcase
  end

  // Store data is shifted into its lane; byte enables keep other lanes intact.
  always_comb begin
    st_data = acc_wdata << {acc_addr[1:0], 3'b000};
    st_be   = '0;
    case (acc_f3)
      3'b000:  st_be = LANES'(1) << acc_addr[1:0];
      3'b001:  st_be = LANES'(3) << {acc_addr[1], 1'b0};
      3'b010:  st_be = '1;
      default: st_be = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d     = req_we;
          addr_d   = req_addr;
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // The counter holds the number of WAIT cycles still to run, this one included.
        if (cnt_q <= 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
          cnt_d      = 4'd0;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    rsp_err_d   = enter_resp & acc_err;
    rsp_rdata_d = (enter_resp & ~acc_we & ~acc_err) ? ld_data : '0;
    mem_we      = enter_resp & acc_we & ~acc_err & ~reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      funct3_q    <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage has no reset; a request aborted by reset never reaches this write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < LANES; k++) begin
        if (st_be[k]) begin
          mem[acc_addr[8:2]][8*k +: 8] <= st_data[8*k +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder

module tb_dmem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m [512];

  dmem_responder #(
    .DATA_W(32),
    .DEPTH_BYTES(512),
    .WAIT_CYCLES(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_funct3(req_funct3),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input bit we, input logic [2:0] f3, input logic [8:0] a);
    case (f3)
      3'b000:  return 1'b1;
      3'b001:  return a[0] == 1'b0;
      3'b010:  return a[1:0] == 2'b00;
      3'b100:  return !we;
      3'b101:  return !we && a[0] == 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [8:0] a);
    int i;
    i = int'(a);
    case (f3)
      3'b000:  return {{24{m[i][7]}}, m[i]};
      3'b001:  return {{16{m[i+1][7]}}, m[i+1], m[i]};
      3'b010:  return {m[i+3], m[i+2], m[i+1], m[i]};
      3'b100:  return {24'h0, m[i]};
      3'b101:  return {16'h0, m[i+1], m[i]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd);
    int n;
    n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    for (int k = 0; k < n; k++) m[int'(a) + k] = wd[8*k +: 8];
  endtask

  task automatic issue(input bit we, input logic [8:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, input bit hold, output longint t_acc);
    int guard;
    guard      = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_funct3 = f3;
    req_wdata  = wd;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("issue_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    t_acc = $time;
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic finish(input bit we, input logic [8:0] a, input logic [2:0] f3,
                        input logic [31:0] wd, output logic [31:0] o_rdata, output logic o_err);
    bit ok;
    logic [31:0] exp_rd;
    ok      = legal(we, f3, a);
    exp_rd  = (ok && !we) ? model_load(f3, a) : 32'h0;
    o_rdata = 32'h0;
    o_err   = 1'b0;
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      check($sformatf("rsp_valid c%0d a%03h f%0d", c, a, f3), {31'h0, rsp_valid}, {31'h0, c == W + 1});
      check($sformatf("req_ready c%0d a%03h f%0d", c, a, f3), {31'h0, req_ready}, {31'h0, c == W + 2});
      if (c == W + 1) begin
        check($sformatf("rsp_rdata a%03h f%0d we%0d", a, f3, we), rsp_rdata, exp_rd);
        check($sformatf("rsp_err a%03h f%0d we%0d", a, f3, we), {31'h0, rsp_err}, {31'h0, !ok});
        o_rdata = rsp_rdata;
        o_err   = rsp_err;
      end else begin
        check($sformatf("quiet_rdata c%0d", c), rsp_rdata, 32'h0);
        check($sformatf("quiet_err c%0d", c), {31'h0, rsp_err}, 32'h0);
      end
    end
    if (ok && we) model_store(f3, a, wd);
  endtask

  task automatic access(input bit we, input logic [8:0] a, input logic [2:0] f3,
                        input logic [31:0] wd, output logic [31:0] o_rdata, output logic o_err);
    longint t;
    issue(we, a, f3, wd, 1'b0, t);
    finish(we, a, f3, wd, o_rdata, o_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    longint      t1, t2;
    logic [8:0]  a;
    logic [2:0]  f3;
    bit          we;

    #1 reset = 1'b1;
    #1;
    check("reset req_ready", {31'h0, req_ready}, 32'h1);
    check("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err", {31'h0, rsp_err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 128; i++) access(1'b1, 9'(i * 4), 3'b010, $urandom, rd, er);

    access(1'b1, 9'h010, 3'b010, 32'hDEADBEEF, rd, er);
    access(1'b0, 9'h010, 3'b010, 32'h0, rd, er);
    check("lw roundtrip", rd, 32'hDEADBEEF);
    check("lw roundtrip err", {31'h0, er}, 32'h0);

    access(1'b1, 9'h010, 3'b010, 32'h11223344, rd, er);
    access(1'b1, 9'h011, 3'b000, 32'h000000AA, rd, er);
    access(1'b0, 9'h010, 3'b010, 32'h0, rd, er);
    check("lw after sb", rd, 32'h1122AA44);
    access(1'b0, 9'h011, 3'b000, 32'h0, rd, er);
    check("lb", rd, 32'hFFFFFFAA);
    access(1'b0, 9'h011, 3'b100, 32'h0, rd, er);
    check("lbu", rd, 32'h000000AA);

    access(1'b1, 9'h012, 3'b001, 32'h00008001, rd, er);
    access(1'b0, 9'h012, 3'b001, 32'h0, rd, er);
    check("lh", rd, 32'hFFFF8001);
    access(1'b0, 9'h012, 3'b101, 32'h0, rd, er);
    check("lhu", rd, 32'h00008001);
    access(1'b0, 9'h010, 3'b010, 32'h0, rd, er);
    check("lw after sh", rd, 32'h8001AA44);

    access(1'b0, 9'h013, 3'b010, 32'h0, rd, er);
    check("misaligned lw err", {31'h0, er}, 32'h1);
    check("misaligned lw rdata", rd, 32'h0);
    access(1'b1, 9'h020, 3'b010, 32'h0, rd, er);
    access(1'b1, 9'h021, 3'b001, 32'h0000FFFF, rd, er);
    check("misaligned sh err", {31'h0, er}, 32'h1);
    access(1'b0, 9'h020, 3'b010, 32'h0, rd, er);
    check("lw after bad sh", rd, 32'h0);
    access(1'b0, 9'h020, 3'b011, 32'h0, rd, er);
    check("funct3 011 err", {31'h0, er}, 32'h1);

    access(1'b1, 9'h040, 3'b010, 32'h0, rd, er);
    issue(1'b1, 9'h040, 3'b010, 32'h12345678, 1'b0, t1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid reset req_ready", {31'h0, req_ready}, 32'h1);
    check("mid reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("held reset req_ready", {31'h0, req_ready}, 32'h1);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    end
    access(1'b0, 9'h040, 3'b010, 32'h0, rd, er);
    check("aborted store", rd, 32'h0);

    issue(1'b1, 9'h1FC, 3'b010, 32'hCAFEF00D, 1'b1, t1);
    req_we     = 1'b0;
    req_wdata  = 32'h0;
    finish(1'b1, 9'h1FC, 3'b010, 32'hCAFEF00D, rd, er);
    issue(1'b0, 9'h1FC, 3'b010, 32'h0, 1'b0, t2);
    check("b2b gap cycles", 32'((t2 - t1) / 10), 32'd4);
    finish(1'b0, 9'h1FC, 3'b010, 32'h0, rd, er);
    check("top of memory lw", rd, 32'hCAFEF00D);

    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      access(we, a, f3, $urandom, rd, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
